// File: rtl/poly_mem_fill.sv
// poly_mem_fill: multi-lane fill engine for polynomial coefficient RAMs.
// On an accepted start it writes `length` coefficients, LANES banks per
// cycle, starting at row base_addr. Coefficient k lands in bank k%LANES at
// row (base_addr + k/LANES) mod 2^ADDR_W. Value is fill_val (mode 0) or
// (fill_val + k) mod 2^DATA_W (mode 1). A one-cycle write_done closes the op.
//
// Optional feature macro: POLY_FILL_VERIFY_EN
//   When defined, a readback pass (VRD/VCMP) follows the writes and any
//   mismatch sets the sticky verify_err. When undefined, mem_re and
//   verify_err are tied low and mem_dout is ignored.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          launch (IDLE only) / cancel (abort wins)
//   mode, base_addr,      operation setup, latched on accepted start
//   length, fill_val
//   mem_addr, mem_din,    bank interface: common row, lane j data at
//   mem_we, mem_re,       [j*DATA_W +: DATA_W], per-bank write enables,
//   mem_dout              read strobe and 1-cycle-latency read data
//   busy, write_done,     status: non-IDLE, completion pulse,
//   verify_err            sticky readback mismatch

// Per-lane value/enable generator: lane LANE_ID of the row whose first
// coefficient index is kbase.
module poly_fill_lane #(
  parameter int DATA_W  = 13,
  parameter int LEN_W   = 12,
  parameter int LANE_ID = 0
) (
  input  logic [LEN_W-1:0]  kbase,
  input  logic [LEN_W-1:0]  len,
  input  logic              mode,
  input  logic [DATA_W-1:0] fill_val,
  output logic              en,
  output logic [DATA_W-1:0] val
);
  logic [LEN_W-1:0] k;
  assign k   = kbase + LEN_W'(LANE_ID);
  assign en  = k < len;
  // Ramp wraps at 2^DATA_W; no reduction to q.
  assign val = mode ? fill_val + DATA_W'(k) : fill_val;
endmodule

module poly_mem_fill #(
  parameter int DATA_W  = 13,
  parameter int ADDR_W  = 11,
  parameter int LANES   = 1,
  parameter int LANE_LG = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic                          mode,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [ADDR_W+LANE_LG:0]       length,
  input  logic [DATA_W-1:0]             fill_val,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [LANES*DATA_W-1:0]       mem_din,
  output logic [LANES-1:0]              mem_we,
  output logic                          mem_re,
  input  logic [LANES*DATA_W-1:0]       mem_dout,
  output logic                          busy,
  output logic                          write_done,
  output logic                          verify_err
);
  localparam int LEN_W = ADDR_W + LANE_LG + 1;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {IDLE, WRITE, VRD, VCMP, DONE} state_t;
  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] val_q;
  logic              mode_q;
  logic [CNT_W-1:0]  cnt;      // row index within the current pass

  logic              accept;
  logic [LEN_W:0]    rows;
  logic              last_row;
  logic [LEN_W-1:0]  kbase;

  logic [LANES-1:0]             wr_en;
  logic [LANES-1:0][DATA_W-1:0] wr_val;

  assign accept   = (state == IDLE) & start & ~abort;
  assign rows     = ({1'b0, len_q} + (LEN_W+1)'(LANES-1)) >> LANE_LG;
  assign last_row = ((LEN_W+1)'(cnt) + (LEN_W+1)'(1)) == rows;
  assign kbase    = LEN_W'(cnt) << LANE_LG;

  for (genvar j = 0; j < LANES; j++) begin : g_wr
    poly_fill_lane #(.DATA_W(DATA_W), .LEN_W(LEN_W), .LANE_ID(j)) u_lane (
      .kbase(kbase), .len(len_q), .mode(mode_q), .fill_val(val_q),
      .en(wr_en[j]), .val(wr_val[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    mem_addr   = '0;
    mem_din    = '0;
    mem_we     = '0;
    mem_re     = 1'b0;
    write_done = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (length == '0) ? DONE : WRITE;
      WRITE: begin
        mem_addr = base_q + cnt[ADDR_W-1:0];
        mem_din  = wr_val;
        // abort kills the row in flight so it never reaches the RAM
        mem_we   = wr_en & {LANES{~abort}};
`ifdef POLY_FILL_VERIFY_EN
        if (last_row) state_nxt = VRD;
`else
        if (last_row) state_nxt = DONE;
`endif
      end
      VRD: begin
        mem_addr = base_q + cnt[ADDR_W-1:0];
`ifdef POLY_FILL_VERIFY_EN
        mem_re   = ~abort;
`endif
        if (last_row) state_nxt = VCMP;
      end
      VCMP: state_nxt = DONE;
      DONE: begin
        write_done = ~abort;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      val_q  <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      base_q <= base_addr;
      len_q  <= length;
      val_q  <= fill_val;
      mode_q <= mode;
      cnt    <= '0;
    end else if (state == WRITE || state == VRD) begin
      cnt <= last_row ? '0 : cnt + CNT_W'(1);
    end
  end

`ifdef POLY_FILL_VERIFY_EN
  // vld_pipe[0]: read issued this cycle; vld_pipe[1]: its data is on mem_dout
  logic [1:0]                   vld_pipe;
  logic [LEN_W-1:0]             rd_kbase;
  logic [LANES-1:0]             rd_en, mis;
  logic [LANES-1:0][DATA_W-1:0] rd_val;
  logic [LANES-1:0][DATA_W-1:0] dout_l;
  logic                         err_q;

  assign vld_pipe[0] = mem_re;
  assign dout_l      = mem_dout;

  for (genvar j = 0; j < LANES; j++) begin : g_rd
    poly_fill_lane #(.DATA_W(DATA_W), .LEN_W(LEN_W), .LANE_ID(j)) u_lane (
      .kbase(rd_kbase), .len(len_q), .mode(mode_q), .fill_val(val_q),
      .en(rd_en[j]), .val(rd_val[j])
    );
    assign mis[j] = rd_en[j] & (dout_l[j] != rd_val[j]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[1] <= 1'b0;
      rd_kbase    <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      rd_kbase    <= kbase;
      if (accept)                   err_q <= 1'b0;
      else if (vld_pipe[1] && |mis) err_q <= 1'b1;
    end
  end
  assign verify_err = err_q;
`else
  logic unused_dout;
  assign unused_dout = ^mem_dout;
  assign verify_err  = 1'b0;
`endif
endmodule

// File: tb/tb_poly_mem_fill.sv
module tb_poly_mem_fill;
  localparam int DATA_W  = 13;
  localparam int ADDR_W  = 11;
  localparam int LANES   = 4;
  localparam int LANE_LG = 2;
  localparam int LEN_W   = ADDR_W + LANE_LG + 1;
  localparam int DEPTH   = 1 << ADDR_W;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     start, abort, mode;
  logic [ADDR_W-1:0]        base_addr;
  logic [LEN_W-1:0]         length;
  logic [DATA_W-1:0]        fill_val;
  logic [ADDR_W-1:0]        mem_addr;
  logic [LANES*DATA_W-1:0]  mem_din;
  logic [LANES-1:0]         mem_we;
  logic                     mem_re;
  logic [LANES*DATA_W-1:0]  mem_dout;
  logic                     busy, write_done, verify_err;

  poly_mem_fill #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LANES(LANES), .LANE_LG(LANE_LG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .length(length), .fill_val(fill_val),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_re(mem_re),
    .mem_dout(mem_dout), .busy(busy), .write_done(write_done), .verify_err(verify_err)
  );

  always #5 clk = ~clk;

  // Bank RAMs seen by the DUT, and the expected contents from the spec rules
  logic [DATA_W-1:0] mem     [LANES][DEPTH];
  logic [DATA_W-1:0] exp_mem [LANES][DEPTH];
  bit                corrupt;
  logic [ADDR_W-1:0] corrupt_row;

  always @(posedge clk) begin
    for (int j = 0; j < LANES; j++) begin
      if (mem_we[j]) mem[j][mem_addr] <= mem_din[j*DATA_W +: DATA_W];
      if (mem_re)
        mem_dout[j*DATA_W +: DATA_W] <= mem[j][mem_addr] ^
          ((corrupt && j == 0 && mem_addr == corrupt_row) ? DATA_W'(1) : DATA_W'(0));
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic mem_cmp(input string tag);
    int nm = 0;
    for (int j = 0; j < LANES; j++)
      for (int a = 0; a < DEPTH; a++)
        if (mem[j][a] !== exp_mem[j][a]) nm++;
    chk(tag, nm, 0);
  endtask

  // Load expected contents for coefficients 0..n-1 of an op
  task automatic model_fill(input logic md, input int b, input int n, input logic [DATA_W-1:0] v);
    for (int k = 0; k < n; k++)
      exp_mem[k % LANES][(b + k / LANES) % DEPTH] = md ? DATA_W'(int'(v) + k) : v;
  endtask

  // Runs one full operation starting at the current negedge.
  task automatic run_op(input string tag, input logic md, input int b, input int len,
                        input logic [DATA_W-1:0] v, input bit cor);
    int rows, exp_done, c, nrow, first, done_c, werr, nre;
    logic err_at_done;
    logic [LANES-1:0] m;
    rows = (len + LANES - 1) / LANES;
`ifdef POLY_FILL_VERIFY_EN
    exp_done = (len == 0) ? 1 : 2 * rows + 2;
`else
    exp_done = (len == 0) ? 1 : rows + 1;
`endif
    model_fill(md, b, len, v);
    corrupt = cor;
    corrupt_row = ADDR_W'(b + 5);
    mode = md; base_addr = ADDR_W'(b); length = LEN_W'(len); fill_val = v;
    start = 1'b1;
    @(posedge clk); #1;
    // start held into a busy cycle with fresh inputs: must not re-latch
    mode = 1'($urandom); base_addr = ADDR_W'($urandom);
    length = LEN_W'($urandom_range(1, 300)); fill_val = DATA_W'($urandom);
    c = 0; nrow = 0; first = -1; done_c = -1; werr = 0; nre = 0; err_at_done = 1'bx;
    while (c < 5000) begin
      @(negedge clk); c++;
      if (c == 2) start = 1'b0;
      if (|mem_we) begin
        if (nrow == 0) first = c;
        for (int j = 0; j < LANES; j++) m[j] = (nrow * LANES + j) < len;
        if (mem_we !== m) werr++;
        nrow++;
      end
      if (mem_re) nre++;
      if (write_done) begin done_c = c; err_at_done = verify_err; break; end
    end
    start = 1'b0;
    chk({tag, ".done_cycle"}, done_c, exp_done);
    chk({tag, ".rows"}, nrow, rows);
    chk({tag, ".we_mask"}, werr, 0);
    if (len > 0) chk({tag, ".first_row"}, first, 1);
`ifdef POLY_FILL_VERIFY_EN
    chk({tag, ".reads"}, nre, rows);
    chk({tag, ".verify_err"}, err_at_done, (cor && len > 5 * LANES) ? 1 : 0);
`else
    chk({tag, ".reads"}, nre, 0);
    chk({tag, ".verify_err"}, err_at_done, 0);
`endif
    @(negedge clk);
    chk({tag, ".busy_after"}, busy, 0);
    chk({tag, ".done_after"}, write_done, 0);
    mem_cmp({tag, ".mem"});
    corrupt = 1'b0;
  endtask

  initial begin
    int b;
    logic [DATA_W-1:0] v;
    rst_n = 1'b0; start = 0; abort = 0; mode = 0; base_addr = '0; length = '0; fill_val = '0;
    corrupt = 0; corrupt_row = '0;
    for (int j = 0; j < LANES; j++)
      for (int a = 0; a < DEPTH; a++) begin
        mem[j][a] = DATA_W'($urandom);
        exp_mem[j][a] = mem[j][a];
      end
    @(negedge clk); @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.we", mem_we, 0);
    chk("rst.re", mem_re, 0);
    chk("rst.done", write_done, 0);
    chk("rst.err", verify_err, 0);
    chk("rst.addr", mem_addr, 0);
    chk("rst.din", mem_din, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Long constant-zero fill
    run_op("zero757", 1'b0, 0, 757, '0, 0);

    // Ramp across the 2^DATA_W boundary with a partial last row
    run_op("ramp10", 1'b1, 40, 10, 13'd8190, 0);
    chk("ramp.k0", mem[0][40], 8190);
    chk("ramp.k1", mem[1][40], 8191);
    chk("ramp.k2", mem[2][40], 0);
    chk("ramp.k9", mem[1][42], 7);

    // Row address wrap
    v = DATA_W'($urandom);
    run_op("wrap", 1'b0, 2046, 16, v, 0);
    chk("wrap.r2046", mem[0][2046], v);
    chk("wrap.r1", mem[3][1], v);

    // Zero length and full-capacity edge
    run_op("len0", 1'b1, 500, 0, 13'd77, 0);
    run_op("len_full", 1'b1, $urandom_range(0, DEPTH-1), LANES * DEPTH, DATA_W'($urandom), 0);

    // Abort during the third write row of a 40-coefficient op
    b = 100;
    model_fill(1'b0, b, 2 * LANES, 13'd1234);
    mode = 0; base_addr = ADDR_W'(b); length = LEN_W'(40); fill_val = 13'd1234; start = 1;
    @(posedge clk); #1; start = 0;
    @(negedge clk); chk("abort.row0_we", mem_we, 4'b1111);
    @(negedge clk); chk("abort.row1_we", mem_we, 4'b1111);
    @(negedge clk); abort = 1'b1; #1;
    chk("abort.we_kill", mem_we, 0);
    chk("abort.no_done", write_done, 0);
    @(negedge clk);
    chk("abort.idle", busy, 0);
    chk("abort.no_done2", write_done, 0);
    abort = 1'b0;
    mem_cmp("abort.mem");
    run_op("after_abort", 1'b1, 1000, 23, DATA_W'($urandom), 0);

    // abort and start together in IDLE: abort wins
    start = 1; abort = 1; length = LEN_W'(8); base_addr = ADDR_W'(1500);
    @(negedge clk);
    chk("abort_start.busy", busy, 0);
    start = 0; abort = 0;
    @(negedge clk);
    chk("abort_start.busy2", busy, 0);
    mem_cmp("abort_start.mem");

    // Randomized operations
    for (int i = 0; i < 6; i++)
      run_op("rand", 1'($urandom), $urandom_range(0, DEPTH-1), $urandom_range(0, 120),
             DATA_W'($urandom), 0);

`ifdef POLY_FILL_VERIFY_EN
    // Readback catches a corrupted word of row 5; next start clears the flag
    run_op("vfy_bad", 1'b0, 300, 30, DATA_W'($urandom), 1);
    run_op("vfy_clean", 1'b1, 700, 30, DATA_W'($urandom), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
